bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   Sits between the arithmetic result register and the per-digit seven-segment
//   decoders. It replaces the combinational /100, %100/10 and %10 logic.
//   Converts one WIDTH-bit unsigned value per start/done handshake.
// PARAMETERS
//   WIDTH   8  binary input width in bits
//   DIGITS  3  number of BCD output digits; elaboration error if 10**DIGITS <= 2**WIDTH-1
// PORTS
//   clk    in   1           system clock; all state updates on the rising edge
//   rst    in   1           asynchronous reset, active high
//   start  in   1           request a conversion; sampled only in IDLE
//   bin    in   WIDTH       unsigned value; captured on the edge that accepts start
//   busy   out  1           high while a conversion is in progress
//   done   out  1           one-cycle pulse when bcd has been updated
//   bcd    out  4*DIGITS    packed BCD, digit 0 (ones) in [3:0]; holds last result
// BEHAVIOUR
//   - Reset (async, active high): state=IDLE, busy=0, done=0, bcd=0,
//     iteration counter=0, shift register=0. Outputs clear immediately, not at the next edge.
//   - FSM states: IDLE, CONV.
//     IDLE: if start==1 at edge E0, go to CONV. Load scratch = {DIGITS*4'd0, bin}
//       and set cnt=0. busy=1 from E0.
//     CONV: on each edge, first add 3 to every scratch BCD digit that is >=5,
//       then shift the whole scratch left by 1. Then cnt=cnt+1.
//       On the edge where cnt==WIDTH-1 (edge E_WIDTH), bcd takes the final digits,
//       done=1, busy=0, and the FSM returns to IDLE.
//   - Latency: done is high in the cycle after edge E_WIDTH, i.e. WIDTH clocks
//     after the accepting edge (8 clocks at default). done is exactly one cycle wide.
//   - Throughput: with start held high, a new conversion is accepted at E_WIDTH+1.
//     The period is WIDTH+1 clocks.
//   - start while busy: ignored, with no queueing. bin changes while busy have no effect.
//   - start while done==1: accepted, because the FSM is already in IDLE.
//   - bcd changes only at the done edge or on reset. It never shows partial values.
//   - Reset mid-conversion: aborts. No done is produced and bcd reads 0.
//   - Width rules: scratch register is 4*DIGITS+WIDTH bits. cnt is $clog2(WIDTH+1) bits.
//     All arithmetic is unsigned. The add-3 is per 4-bit digit, with no carry between digits.
//   - Values are always in range at default parameters: max 255 gives 12'h255.
// STRUCTURE
//   - Shared package/include: FSM state encodings (ST_IDLE=1'b0, ST_CONV=1'b1),
//     BCD_DIGIT_W=4, and the BCD blank/zero constants used by the display path.
//   - One sub-module: bcd_add3, combinational, 4-bit in and 4-bit out (d>=5 ? d+3 : d).
//     It is instantiated DIGITS times with a generate loop.
//   - Top-level usage: the display top asserts start when the result changes.
//     The seven-segment decoders take bcd[11:8], bcd[7:4] and bcd[3:0].
// TESTING
//   1. bin=0, start pulse -> done exactly 8 clocks after accept, bcd=12'h000.
//   2. bin=255 -> bcd=12'h255. Also bin=100 -> 12'h100 and bin=99 -> 12'h099.
//   3. Accept bin=200, then pulse start with bin=7 at clocks 2 and 5 ->
//      a single done, with bcd=12'h200.
//   4. Assert rst at clock 4 of a conversion of 123 -> busy, done and bcd are 0
//      at once, and no done follows.
//   5. Hold start high with bin cycling 10, 20, 30 -> a done every 9 clocks,
//      with bcd = 12'h010, 12'h020, 12'h030 in that order.
//   6. Exhaustive sweep of bin 0..255 against a behavioural /100, %10 model.
//      Also check that bcd is stable between done pulses.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter and display path.
package bin2bcd_seq_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  // Digit codes the seven-segment decoders treat as "0" and "all segments off".
  localparam logic [BCD_DIGIT_W-1:0] BCD_ZERO  = 4'h0;
  localparam logic [BCD_DIGIT_W-1:0] BCD_BLANK = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_e;

  // 10**n for elaboration-time range checks.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_add3
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  // Add 3 when the digit would overflow past 9 after doubling.
  always_comb begin
    adjusted = digit;
    if (digit >= BCD_DIGIT_W'(5)) begin
      adjusted = digit + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one value per start/done handshake.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned SCR_W = BCD_W + WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  // Refuse parameter sets where the largest input cannot be represented.
  if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_range_check
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end

  state_e            state_q, state_d;
  logic [SCR_W-1:0]  scratch_q, scratch_d;
  logic [SCR_W-1:0]  adj;
  logic [SCR_W-1:0]  shifted;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_d, done_d;
  logic [BCD_W-1:0]  bcd_d;

  // Binary part passes through untouched; each BCD digit is corrected independently.
  assign adj[WIDTH-1:0] = scratch_q[WIDTH-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .digit    (scratch_q[WIDTH + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (adj[WIDTH + g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign shifted = {adj[SCR_W-2:0], 1'b0};

  // State, scratch, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      bcd       <= bcd_d;
    end
  end

  // Next-state and next-output logic; done is a single-cycle pulse by default-low.
  always_comb begin
    state_d   = state_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    busy_d    = busy;
    done_d    = 1'b0;
    bcd_d     = bcd;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CONV;
          scratch_d = {BCD_W'(0), bin};
          cnt_d     = '0;
          busy_d    = 1'b1;
        end
      end
      ST_CONV: begin
        scratch_d = shifted;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bcd_d   = shifted[SCR_W-1 -: BCD_W];
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against a divide/modulo reference model.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // One full conversion from IDLE; checks latency, result, pulse width and bcd stability.
  task automatic run_conv(input logic [7:0] v);
    int n;
    logic [11:0] prev;
    logic stable;
    @(negedge clk);
    prev  = bcd;
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    bin    = 8'($urandom);
    n      = 0;
    stable = 1'b1;
    check("busy_after_accept", 32'(busy), 32'd1);
    while (!done && n < 20) begin
      if (bcd !== prev) stable = 1'b0;
      if ($urandom_range(0, 3) == 0) start = 1'b1;
      else start = 1'b0;
      bin = 8'($urandom);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("latency", 32'(n), 32'd8);
    check("bcd_stable", 32'(stable), 32'd1);
    check("bcd_value", 32'(bcd), 32'(ref_bcd(int'(v))));
    check("busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int dones;
    int last_t;
    int idx;
    int vals[3];
    logic [11:0] res[$];

    rst   = 1'b1;
    start = 1'b0;
    bin   = 8'd0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd",  32'(bcd),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed values including boundaries.
    run_conv(8'd0);
    run_conv(8'd255);
    run_conv(8'd100);
    run_conv(8'd99);

    // Start pulses while busy are ignored.
    @(negedge clk);
    start = 1'b1; bin = 8'd200;
    @(negedge clk);
    start = 1'b0; bin = 8'd7;
    dones = 0;
    for (int k = 1; k < 25; k++) begin
      if (k == 2 || k == 5) start = 1'b1;
      else start = 1'b0;
      @(negedge clk);
      if (done) begin
        dones++;
        check("busy_start_bcd", 32'(bcd), 32'h200);
      end
    end
    start = 1'b0;
    check("busy_start_single_done", 32'(dones), 32'd1);

    // Asynchronous reset mid-conversion.
    @(negedge clk);
    start = 1'b1; bin = 8'd123;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_bcd",  32'(bcd),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    check("midrst_bcd_hold", 32'(bcd), 32'd0);

    // Back-to-back with start held high.
    vals[0] = 10; vals[1] = 20; vals[2] = 30;
    idx = 0;
    last_t = -1;
    @(negedge clk);
    start = 1'b1; bin = 8'(vals[0]);
    for (int k = 0; k < 60 && idx < 3; k++) begin
      @(negedge clk);
      if (done) begin
        res.push_back(bcd);
        if (last_t >= 0) check("b2b_period", 32'(cyc - last_t), 32'd9);
        last_t = cyc;
        idx++;
        if (idx < 3) bin = 8'(vals[idx]);
        else start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(res.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < res.size()) check("b2b_bcd", 32'(res[k]), 32'(ref_bcd(vals[k])));
    end
    repeat (12) @(negedge clk);

    // Exhaustive sweep then random values.
    for (int v = 0; v < 256; v++) run_conv(8'(v));
    repeat (40) run_conv(8'($urandom));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
